vga_fetch_controller: RTL and testbench

Sequences framebuffer reads for the VGA pipeline through the shared memory request handler. Walks the framebuffer linearly from a base address and keeps a show-ahead word FIFO filled for the pixel generator. Drives `VGA_state` so that VGA holds the memory slot when the FIFO is nearly empty, shares it round-robin when comfortable, and releases it after the frame is fetched. Sits between the request handler's VGA port and the pixel generator.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/vga_fetch_controller.sv | 119 +++++++++++
 tb/tb_vga_fetch_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-arbitration types used by the request handler and its clients.
package mem_pkg;

  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    READY    = 2'd1,
    ACTIVE   = 2'd2
  } VGA_state_t;

  typedef enum logic [1:0] {
    CLIENT_NONE = 2'd0,
    CLIENT_CPU  = 2'd1,
    CLIENT_VGA  = 2'd2
  } client_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;

  // Byte address of a 32-bit word; shift first so the add is full 32-bit.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head presents the oldest entry, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fetch_controller.sv
// Walks the framebuffer through the shared request handler and keeps the
// pixel generator's word FIFO topped up, raising VGA priority when it runs low.
module vga_fetch_controller
  import mem_pkg::*;
#(
  parameter logic [31:0] FB_BASE     = 32'h0000_2000,
  parameter int          FRAME_WORDS = 9600,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          LOW_WATER   = 2
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        mem_busy,
  input  logic        VGA_enable,
  input  logic [31:0] data_to_VGA,
  output VGA_state_t  VGA_state,
  output logic        VGA_read,
  output logic [31:0] VGA_adr,
  input  logic        pix_pop,
  output logic [31:0] pix_word,
  output logic        pix_valid,
  output logic        underrun
);

  localparam int FILL_W = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int USED_W = CNT_W + 1;

  fetch_state_t      r_state;
  logic [FILL_W-1:0] r_fill_idx;
  logic              r_read_q;
  logic [31:0]       r_adr_q;
  logic              r_underrun;

  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic [FILL_W-1:0] w_issue_idx;
  logic [USED_W-1:0] w_slots_used;
  logic [31:0]       w_expect_adr;

  // A response is only trusted if it answers the request for the next word in order.
  assign w_expect_adr = word_addr(FB_BASE, 32'(r_fill_idx));
  assign w_accept     = VGA_enable & r_read_q & (r_adr_q == w_expect_adr);
  assign w_issue_idx  = r_fill_idx + FILL_W'(w_accept);
  assign w_push       = w_accept & ~frame_start & ~w_full;

  // The in-flight word already owns a slot, so it is counted before asking for more.
  assign w_slots_used = USED_W'(w_count) + USED_W'(r_read_q);
  assign VGA_read     = (r_state == ST_FETCH)
                      & (w_slots_used < USED_W'(FIFO_DEPTH))
                      & (int'(w_issue_idx) < FRAME_WORDS);
  assign VGA_adr      = word_addr(FB_BASE, 32'(w_issue_idx));

  assign pix_valid = ~w_empty;
  assign underrun  = r_underrun;

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    VGA_state = INACTIVE;
    if (r_state == ST_FETCH) begin
      VGA_state = (w_count <= CNT_W'(LOW_WATER)) ? ACTIVE : READY;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else if (!enable) begin
      r_state <= ST_IDLE;
    end else if (frame_start) begin
      r_state <= ST_FETCH;
    end else if (r_state == ST_FETCH && int'(r_fill_idx) == FRAME_WORDS) begin
      r_state <= ST_DONE;
    end
  end

  // Tag registers only move when the handler can sample, so a busy stall keeps the request intact.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_fill_idx <= '0;
      r_read_q   <= 1'b0;
      r_adr_q    <= FB_BASE;
      r_underrun <= 1'b0;
    end else begin
      if (!mem_busy) r_adr_q <= VGA_adr;
      if (frame_start) begin
        r_fill_idx <= '0;
        r_read_q   <= 1'b0;
        r_underrun <= 1'b0;
      end else begin
        if (w_accept)         r_fill_idx <= w_issue_idx;
        if (!mem_busy)        r_read_q   <= VGA_read;
        if (pix_pop & w_empty) r_underrun <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nRst      (nRst),
    .flush     (frame_start),
    .push      (w_push),
    .push_data (data_to_VGA),
    .pop       (pix_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (pix_word)
  );

endmodule

// File: tb/tb_vga_fetch_controller.sv
// Directed bench for vga_fetch_controller with a one-slot request handler model.
module tb_vga_fetch_controller;

  localparam logic [1:0] S_INACTIVE = 2'd0;
  localparam logic [1:0] S_READY    = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        mem_busy = 1'b0;
  logic        VGA_enable = 1'b0;
  logic [31:0] data_to_VGA = '0;
  logic [1:0]  VGA_state;
  logic        VGA_read;
  logic [31:0] VGA_adr;
  logic        pix_pop = 1'b0;
  logic [31:0] pix_word;
  logic        pix_valid;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int exp_idx  = 0;

  logic        hv_pending = 1'b0;
  logic [31:0] hv_adr = '0;

  vga_fetch_controller #(
    .FB_BASE     (32'h0000_2000),
    .FRAME_WORDS (16),
    .FIFO_DEPTH  (8),
    .LOW_WATER   (2)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .enable      (enable),
    .frame_start (frame_start),
    .mem_busy    (mem_busy),
    .VGA_enable  (VGA_enable),
    .data_to_VGA (data_to_VGA),
    .VGA_state   (VGA_state),
    .VGA_read    (VGA_read),
    .VGA_adr     (VGA_adr),
    .pix_pop     (pix_pop),
    .pix_word    (pix_word),
    .pix_valid   (pix_valid),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input int i);
    logic [31:0] a;
    a = 32'h0000_2000 + 32'(i) * 32'd4;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Handler model: answers a request sampled in one non-busy cycle in the next non-busy cycle.
  task automatic settle(input bit stale = 1'b0);
    if (!mem_busy) begin
      VGA_enable  = hv_pending | stale;
      data_to_VGA = hv_pending ? (hv_adr ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;
    end else begin
      VGA_enable  = 1'b0;
    end
    #1;
    if (!mem_busy) begin
      hv_pending = VGA_read;
      hv_adr     = VGA_adr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    // Reset and idle
    tick();
    tick();
    nRst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      check("idle_state", 32'(VGA_state), 32'(S_INACTIVE));
      check("idle_read", 32'(VGA_read), 32'd0);
      check("idle_adr", VGA_adr, 32'h2000);
      check("idle_valid", 32'(pix_valid), 32'd0);
      check("idle_word", pix_word, 32'd0);
      tick();
    end

    // Fill from empty, with a stale strobe in the first FETCH cycle
    enable = 1'b1;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    settle(1'b1);
    check("stale_adr", VGA_adr, 32'h2000);
    check("stale_read", 32'(VGA_read), 32'd1);
    check("fill0_state", 32'(VGA_state), 32'(S_ACTIVE));
    tick();
    for (int k = 0; k < 8; k++) begin
      settle();
      check("fill_state", 32'(VGA_state), (k <= 2) ? 32'(S_ACTIVE) : 32'(S_READY));
      check("fill_read", 32'(VGA_read), (k < 7) ? 32'd1 : 32'd0);
      check("fill_adr", VGA_adr, 32'h2000 + 32'(k + 1) * 32'd4);
      check("fill_valid", 32'(pix_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) check("fill_head", pix_word, data_of(0));
      tick();
    end
    settle();
    check("full_state", 32'(VGA_state), 32'(S_READY));
    check("full_read", 32'(VGA_read), 32'd0);
    check("full_head", pix_word, data_of(0));
    tick();

    // Simultaneous push and pop at count 7
    pix_pop = 1'b1;
    settle();
    check("p1_read", 32'(VGA_read), 32'd0);
    check("p1_head", pix_word, data_of(0));
    tick();
    pix_pop = 1'b0;
    settle();
    check("p2_head", pix_word, data_of(1));
    check("p2_read", 32'(VGA_read), 32'd1);
    check("p2_adr", VGA_adr, 32'h2020);
    tick();
    pix_pop = 1'b1;
    settle();
    check("p3_head", pix_word, data_of(1));
    check("p3_read", 32'(VGA_read), 32'd0);
    check("p3_adr", VGA_adr, 32'h2024);
    tick();
    pix_pop = 1'b0;
    settle();
    check("p4_head", pix_word, data_of(2));
    check("p4_read", 32'(VGA_read), 32'd1);
    check("p4_adr", VGA_adr, 32'h2024);
    check("p4_state", 32'(VGA_state), 32'(S_READY));
    tick();

    // Frame end with continuous pops
    exp_idx = 2;
    for (int n = 0; n < 200 && exp_idx < 16; n++) begin
      pix_pop = pix_valid;
      if (pix_valid) begin
        check("drain_word", pix_word, data_of(exp_idx));
        exp_idx++;
      end
      settle();
      tick();
    end
    pix_pop = 1'b0;
    check("drain_count", 32'(exp_idx), 32'd16);
    settle();
    check("done_state", 32'(VGA_state), 32'(S_INACTIVE));
    check("done_read", 32'(VGA_read), 32'd0);
    check("done_valid", 32'(pix_valid), 32'd0);
    check("done_underrun", 32'(underrun), 32'd0);
    tick();

    // Underrun is sticky
    pix_pop = 1'b1;
    cyc();
    pix_pop = 1'b0;
    settle();
    check("underrun_set", 32'(underrun), 32'd1);
    tick();
    cyc();
    cyc();
    settle();
    check("underrun_sticky", 32'(underrun), 32'd1);
    tick();

    // Flush with five words buffered
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    pix_pop = 1'b1;
    cyc();
    pix_pop = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    frame_start = 1'b1;
    settle();
    check("preflush_valid", 32'(pix_valid), 32'd1);
    check("preflush_head", pix_word, data_of(0));
    check("preflush_underrun", 32'(underrun), 32'd1);
    tick();
    frame_start = 1'b0;
    settle();
    check("flush_valid", 32'(pix_valid), 32'd0);
    check("flush_underrun", 32'(underrun), 32'd0);
    check("flush_adr", VGA_adr, 32'h2000);
    check("flush_state", 32'(VGA_state), 32'(S_ACTIVE));
    tick();

    // Busy stall on the request for 0x2008
    cyc();
    settle();
    check("stall_req_adr", VGA_adr, 32'h2008);
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_hold_adr", VGA_adr, 32'h2008);
      tick();
    end
    mem_busy = 1'b0;
    settle();
    check("stall_accept_adr", VGA_adr, 32'h200C);
    tick();
    settle();
    check("stall_next_adr", VGA_adr, 32'h2010);
    tick();
    exp_idx = 0;
    for (int n = 0; n < 50 && exp_idx < 6; n++) begin
      pix_pop = pix_valid;
      if (pix_valid) begin
        check("stall_word", pix_word, data_of(exp_idx));
        exp_idx++;
      end
      settle();
      tick();
    end
    pix_pop = 1'b0;
    check("stall_count", 32'(exp_idx), 32'd6);

    // Asynchronous reset mid-frame
    #3;
    nRst = 1'b0;
    #1;
    check("rst_state", 32'(VGA_state), 32'(S_INACTIVE));
    check("rst_read", 32'(VGA_read), 32'd0);
    check("rst_adr", VGA_adr, 32'h2000);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_word", pix_word, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
